alu_sched: RTL and testbench
============================

# alu_sched

Sequencing and arbitration controller for the team's shared 4-bit ALU, which has an 8-bit result and a 3-bit op select. Two requesters compete for the single ALU through valid/ready handshakes, and grants follow round-robin order. The block drives the ALU operands and op select with registered values and holds them stable for an op-dependent latency. It then captures the ALU result and returns it on one response channel tagged with the requester ID. Divide-by-zero is trapped in the controller and never reaches the ALU.

## Interface
- MUL_LAT, 2: cycles the ALU inputs are held for op 2 (multiply); legal range 1–15.
- DIV_LAT, 3: cycles held for op 3 (divide); legal range 1–15.
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  2  per-port request valid; bit i belongs to port i.
- req_ready  out  2  per-port grant/accept; at most one bit high in any cycle.
- req_a0, req_b0  in  4 each  operands, port 0.
- req_sl0  in  3  op select, port 0 (0 add, 1 sub, 2 mul, 3 div/mod, 4 or, 5 and, 6 xor, 7 shift).
- req_a1, req_b1, req_sl1  in  4/4/3  same as port 0, for port 1.
- alu_a, alu_b  out  4 each  registered operands to the ALU.
- alu_sl  out  3  registered op select to the ALU.
- alu_en  out  1  high while the ALU is executing (EXEC state).
- alu_out  in  8  ALU result.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_data  out  8  captured result.
- rsp_id  out  1  requester that owns the response.
- rsp_err  out  1  response is a trapped divide-by-zero.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - Arbitrate across asserted req_valid bits.
  - If only one port is valid, it wins.
  - If both are valid, the winner is the port not granted last. The last-grant register resets to 1, so port 0 wins first.
  - Assert req_ready[winner] combinationally for that one cycle. Latch a, b, sl and id.
  - Normal case: load alu_a/alu_b/alu_sl from the winner's inputs, clear the latency counter, go to EXEC.
  - Trap case (winner sl==3 and b==0): do not update alu_* and do not enter EXEC. Load rsp_data=8'hFF, rsp_err=1, rsp_id=winner, go to RESP.
- **EXEC**
  - alu_en=1 and alu_* are held constant.
  - Latency L is 1 for ops 0,1,4,5,6,7, MUL_LAT for op 2, and DIV_LAT for op 3.
  - The counter increments each cycle. In the cycle where counter==L-1: rsp_data<=alu_out, rsp_err<=0, rsp_id<=latched id, next state RESP.
- **RESP**
  - rsp_valid=1. rsp_data, rsp_id and rsp_err are stable until accepted.
  - No grants are issued; req_ready=0.
  - On rsp_ready=1, go to IDLE; the new arbitration happens in the following cycle.
- Results are not modified. Width, overflow and div/mod packing are properties of the ALU: add/sub wrap to 8 bits, div returns {quotient, remainder}.
- Requests are not queued. A requester holds req_valid and its operands until it sees req_ready.
- req_valid deasserted before grant is legal: the request is dropped, with no state change.

## Timing
- Reset values: state=IDLE, req_ready=0, rsp_valid=0, rsp_data=8'h00, rsp_id=0, rsp_err=0, alu_a=0, alu_b=0, alu_sl=0, alu_en=0, busy=0, last-grant=1.
- Reset asserted in any state, including mid-EXEC or RESP with rsp_valid high: the next cycle is IDLE with all reset values. Any in-flight result is discarded and no response is produced.
- Normal op, grant in cycle T:
  - EXEC occupies T+1..T+L.
  - rsp_valid is first high in cycle T+L+1.
- Trapped divide, grant in cycle T: rsp_valid is first high in cycle T+1.
- Minimum grant-to-grant spacing is L+2 cycles (trap: 2 cycles) when rsp_ready is held high.
- rsp_ready is sampled only in RESP; a high value in other states is ignored.
- last-grant is updated in the grant cycle, including trapped requests.

## Test plan
- Port 0: a=5, b=3, sl=0, rsp_ready=1 → req_ready[0] high at T; alu_en high at T+1 only; rsp_valid at T+2 with rsp_data=8'h08, rsp_id=0, rsp_err=0.
- Port 1: a=15, b=15, sl=2, MUL_LAT=2 → alu_en high T+1..T+2, alu_a/alu_b stable at 4'hF; rsp at T+3 with 8'hE1, rsp_id=1.
- Port 0: a=13, b=4, sl=3 → rsp 8'h31 at T+4. Then a=7, b=0, sl=3 → rsp 8'hFF, rsp_err=1 at T+1, and alu_en never asserted.
- Both ports request continuously with rsp_ready=1 → grants alternate 0,1,0,1. req_ready is never two-hot. Each rsp_id matches its granted port.
- Backpressure: rsp_ready=0 for 5 cycles in RESP → rsp_data/rsp_id/rsp_err held stable; req_ready stays 0 despite pending requests. Grant occurs 1 cycle after the accept.
- rst=1 during an EXEC of op 3 → next cycle IDLE with all outputs at reset values, no rsp_valid. The first grant after reset goes to port 0 when both ports are valid.

Source files
------------

// File: rtl/alu_sched.sv
// alu_sched: round-robin arbiter and op sequencer for a shared 4-bit ALU.
// Ports:
//   clk, rst                  clock, sync active-high reset
//   req_valid_i/req_ready_o   per-port request handshake (bit i = port i)
//   req_{a,b,sl}{0,1}_i       per-port operands and op select
//   alu_{a,b,sl}_o, alu_en_o  registered ALU drive, enable while executing
//   alu_out_i                 ALU result
//   rsp_*                     response channel (data, id, trap flag)
//   busy_o                    controller not idle
module alu_sched #(
    parameter int unsigned MUL_LAT = 2,
    parameter int unsigned DIV_LAT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_valid_i,
    output logic [1:0] req_ready_o,
    input  logic [3:0] req_a0_i,
    input  logic [3:0] req_b0_i,
    input  logic [2:0] req_sl0_i,
    input  logic [3:0] req_a1_i,
    input  logic [3:0] req_b1_i,
    input  logic [2:0] req_sl1_i,
    output logic [3:0] alu_a_o,
    output logic [3:0] alu_b_o,
    output logic [2:0] alu_sl_o,
    output logic       alu_en_o,
    input  logic [7:0] alu_out_i,
    output logic       rsp_valid_o,
    input  logic       rsp_ready_i,
    output logic [7:0] rsp_data_o,
    output logic       rsp_id_o,
    output logic       rsp_err_o,
    output logic       busy_o
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t     state_q, state_d;
    logic       last_q, last_d, id_q, id_d;
    logic [3:0] cnt_q, cnt_d, a_q, a_d, b_q, b_d;
    logic [2:0] sl_q, sl_d;
    logic [7:0] data_q, data_d;
    logic       rid_q, rid_d, err_q, err_d;
    logic       win, trap;
    logic [3:0] win_a, win_b, lat;
    logic [2:0] win_sl;
    // both valid: favour the port not granted last
    assign win    = &req_valid_i ? ~last_q : req_valid_i[1];
    assign win_a  = win ? req_a1_i : req_a0_i;
    assign win_b  = win ? req_b1_i : req_b0_i;
    assign win_sl = win ? req_sl1_i : req_sl0_i;
    assign trap   = win_sl == 3'd3 && win_b == 4'd0;
    assign lat    = sl_q == 3'd2 ? 4'(MUL_LAT) : sl_q == 3'd3 ? 4'(DIV_LAT) : 4'd1;
    assign alu_a_o     = a_q;
    assign alu_b_o     = b_q;
    assign alu_sl_o    = sl_q;
    assign alu_en_o    = state_q == EXEC;
    assign rsp_valid_o = state_q == RESP;
    assign rsp_data_o  = data_q;
    assign rsp_id_o    = rid_q;
    assign rsp_err_o   = err_q;
    assign busy_o      = state_q != IDLE;
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        id_d        = id_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        sl_d        = sl_q;
        data_d      = data_q;
        rid_d       = rid_q;
        err_d       = err_q;
        req_ready_o = 2'b00;
        case (state_q)
            IDLE: if (|req_valid_i && !rst) begin
                req_ready_o = win ? 2'b10 : 2'b01;
                last_d      = win;
                id_d        = win;
                if (trap) begin
                    // divide-by-zero never reaches the ALU; alu_* keep old values
                    data_d  = 8'hFF;
                    err_d   = 1'b1;
                    rid_d   = win;
                    state_d = RESP;
                end else begin
                    a_d     = win_a;
                    b_d     = win_b;
                    sl_d    = win_sl;
                    cnt_d   = 4'd0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == lat - 4'd1) begin
                    data_d  = alu_out_i;
                    err_d   = 1'b0;
                    rid_d   = id_q;
                    state_d = RESP;
                end
            end
            RESP: state_d = rsp_ready_i ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sl_q    <= '0;
            data_q  <= '0;
            rid_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sl_q    <= sl_d;
            data_q  <= data_d;
            rid_q   <= rid_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: directed self-checking bench for alu_sched with a behavioural ALU.
module tb_alu_sched;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req_valid, req_ready;
    logic [3:0] a0, b0, a1, b1, alu_a, alu_b;
    logic [2:0] sl0, sl1, alu_sl;
    logic       alu_en, rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
    logic [7:0] alu_out, rsp_data;
    int         vec = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    always_comb begin
        alu_out = 8'h00;
        case (alu_sl)
            3'd0: alu_out = {4'h0, alu_a} + {4'h0, alu_b};
            3'd1: alu_out = {4'h0, alu_a} - {4'h0, alu_b};
            3'd2: alu_out = {4'h0, alu_a} * {4'h0, alu_b};
            3'd3: alu_out = alu_b == 4'd0 ? 8'h00 : {alu_a / alu_b, alu_a % alu_b};
            3'd4: alu_out = {4'h0, alu_a | alu_b};
            3'd5: alu_out = {4'h0, alu_a & alu_b};
            3'd6: alu_out = {4'h0, alu_a ^ alu_b};
            default: alu_out = {4'h0, alu_a} << alu_b[1:0];
        endcase
    end

    alu_sched #(.MUL_LAT(2), .DIV_LAT(3)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_a0_i(a0), .req_b0_i(b0), .req_sl0_i(sl0),
        .req_a1_i(a1), .req_b1_i(b1), .req_sl1_i(sl1),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_sl_o(alu_sl), .alu_en_o(alu_en),
        .alu_out_i(alu_out),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_data_o(rsp_data), .rsp_id_o(rsp_id), .rsp_err_o(rsp_err),
        .busy_o(busy)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vec++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b0;
        a0 = 0; b0 = 0; sl0 = 0; a1 = 0; b1 = 0; sl1 = 0;
        tick(); tick();
        chk("rst_ready", {6'd0, req_ready}, 8'h00);
        chk("rst_valid", {7'd0, rsp_valid}, 8'h00);
        chk("rst_data", rsp_data, 8'h00);
        chk("rst_id_err", {6'd0, rsp_id, rsp_err}, 8'h00);
        chk("rst_alu", {alu_a, alu_b}, 8'h00);
        chk("rst_en_busy", {5'd0, alu_sl}, 8'h00);
        chk("rst_en_busy2", {6'd0, alu_en, busy}, 8'h00);
        rst = 1'b0;
        tick();
        // add on port 0
        rsp_ready = 1'b1; req_valid = 2'b01; a0 = 5; b0 = 3; sl0 = 0;
        #1;
        chk("add_grant", {6'd0, req_ready}, 8'h01);
        chk("add_busy0", {7'd0, busy}, 8'h00);
        tick(); req_valid = 2'b00; #1;
        chk("add_en", {7'd0, alu_en}, 8'h01);
        chk("add_ops", {alu_a, alu_b}, 8'h53);
        chk("add_novalid", {7'd0, rsp_valid}, 8'h00);
        tick(); #1;
        chk("add_en_off", {7'd0, alu_en}, 8'h00);
        chk("add_rvalid", {7'd0, rsp_valid}, 8'h01);
        chk("add_data", rsp_data, 8'h08);
        chk("add_id_err", {6'd0, rsp_id, rsp_err}, 8'h00);
        tick(); #1;
        chk("add_idle", {6'd0, busy, rsp_valid}, 8'h00);
        // multiply on port 1
        req_valid = 2'b10; a1 = 15; b1 = 15; sl1 = 2;
        #1;
        chk("mul_grant", {6'd0, req_ready}, 8'h02);
        tick(); req_valid = 2'b00; #1;
        chk("mul_en1", {7'd0, alu_en}, 8'h01);
        chk("mul_ops1", {alu_a, alu_b}, 8'hFF);
        tick(); #1;
        chk("mul_en2", {7'd0, alu_en}, 8'h01);
        chk("mul_ops2", {alu_a, alu_b}, 8'hFF);
        chk("mul_novalid", {7'd0, rsp_valid}, 8'h00);
        tick(); #1;
        chk("mul_rvalid", {7'd0, rsp_valid}, 8'h01);
        chk("mul_data", rsp_data, 8'hE1);
        chk("mul_id_err", {6'd0, rsp_id, rsp_err}, 8'h02);
        tick(); #1;
        // divide on port 0
        req_valid = 2'b01; a0 = 13; b0 = 4; sl0 = 3;
        #1;
        chk("div_grant", {6'd0, req_ready}, 8'h01);
        tick(); req_valid = 2'b00; #1;
        chk("div_en1", {7'd0, alu_en}, 8'h01);
        tick(); #1;
        chk("div_en2", {7'd0, alu_en}, 8'h01);
        tick(); #1;
        chk("div_en3", {7'd0, alu_en}, 8'h01);
        chk("div_novalid", {7'd0, rsp_valid}, 8'h00);
        tick(); #1;
        chk("div_rvalid", {7'd0, rsp_valid}, 8'h01);
        chk("div_data", rsp_data, 8'h31);
        chk("div_id_err", {6'd0, rsp_id, rsp_err}, 8'h00);
        tick(); #1;
        // trapped divide by zero
        req_valid = 2'b01; a0 = 7; b0 = 0; sl0 = 3;
        #1;
        chk("trap_grant", {6'd0, req_ready}, 8'h01);
        tick(); req_valid = 2'b00; #1;
        chk("trap_rvalid", {7'd0, rsp_valid}, 8'h01);
        chk("trap_data", rsp_data, 8'hFF);
        chk("trap_id_err", {6'd0, rsp_id, rsp_err}, 8'h01);
        chk("trap_en", {7'd0, alu_en}, 8'h00);
        chk("trap_alu_held", {alu_a, alu_b}, 8'hD4);
        tick(); #1;
        chk("trap_idle", {7'd0, busy}, 8'h00);
        // round robin with both ports requesting continuously
        a0 = 1; b0 = 2; sl0 = 0; a1 = 4; b1 = 3; sl1 = 4; req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_grant", {6'd0, req_ready}, (i % 2 == 0) ? 8'h02 : 8'h01);
            tick(); #1;
            chk("rr_exec_ready", {6'd0, req_ready}, 8'h00);
            chk("rr_en", {7'd0, alu_en}, 8'h01);
            tick(); #1;
            chk("rr_rvalid", {7'd0, rsp_valid}, 8'h01);
            chk("rr_id", {7'd0, rsp_id}, (i % 2 == 0) ? 8'h01 : 8'h00);
            chk("rr_data", rsp_data, (i % 2 == 0) ? 8'h07 : 8'h03);
            chk("rr_resp_ready", {6'd0, req_ready}, 8'h00);
            tick();
        end
        // backpressure
        rsp_ready = 1'b0;
        #1;
        chk("bp_grant", {6'd0, req_ready}, 8'h02);
        tick(); #1;
        chk("bp_en", {7'd0, alu_en}, 8'h01);
        tick();
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_rvalid", {7'd0, rsp_valid}, 8'h01);
            chk("bp_data", rsp_data, 8'h07);
            chk("bp_id_err", {6'd0, rsp_id, rsp_err}, 8'h02);
            chk("bp_ready", {6'd0, req_ready}, 8'h00);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_accept_valid", {7'd0, rsp_valid}, 8'h01);
        chk("bp_accept_ready", {6'd0, req_ready}, 8'h00);
        tick();
        // grant right after accept, then reset mid-divide
        req_valid = 2'b01; a0 = 13; b0 = 4; sl0 = 3;
        #1;
        chk("post_bp_grant", {6'd0, req_ready}, 8'h01);
        tick(); req_valid = 2'b11; #1;
        chk("rst_div_en", {7'd0, alu_en}, 8'h01);
        chk("rst_div_sl", {5'd0, alu_sl}, 8'h03);
        rst = 1'b1;
        tick(); #1;
        chk("mid_rst_busy_en", {6'd0, busy, alu_en}, 8'h00);
        chk("mid_rst_valid", {7'd0, rsp_valid}, 8'h00);
        chk("mid_rst_data", rsp_data, 8'h00);
        chk("mid_rst_alu", {alu_a, alu_b}, 8'h00);
        chk("mid_rst_sl", {5'd0, alu_sl}, 8'h00);
        chk("mid_rst_ready", {6'd0, req_ready}, 8'h00);
        rst = 1'b0;
        #1;
        chk("post_rst_grant", {6'd0, req_ready}, 8'h01);
        tick(); #1;
        chk("post_rst_en", {7'd0, alu_en}, 8'h01);
        chk("post_rst_ops", {alu_a, alu_b}, 8'hD4);
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
